calc_addsub_seq: RTL and testbench
==================================

Name: calc_addsub_seq

Overview:
- Parametrised, multi-cycle unsigned adder/subtractor for the calc datapath.
- Generalises the fixed 4-bit ripple adder:
  - operand width is set by WIDTH;
  - operands are processed CHUNK bits per clock;
  - subtract mode is added;
  - a START/BUSY/DONE handshake is added.
- Result width is WIDTH+2, matching the calc convention: carry/borrow bit plus sign/pad bit above the sum.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits added per clock cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE or DONE state.
- MODE  in  1  0 = add (A+B), 1 = subtract (A−B); latched with START.
- A_DATA  in  WIDTH  operand A, unsigned; latched with START.
- B_DATA  in  WIDTH  operand B, unsigned; latched with START.
- BUSY  out  1  high while state is RUN.
- DONE  out  1  one-cycle pulse; RES_DATA valid.
- RES_DATA  out  WIDTH+2  result.
- ZERO  out  1  RES_DATA == 0; valid when DONE is high, held afterwards.

Behaviour:
- One clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset (RST_N low, at any time, including mid-operation):
  - state → IDLE; BUSY=0, DONE=0, RES_DATA=0, ZERO=0;
  - chunk counter and internal operand/accumulator registers cleared;
  - after release, the first START is handled normally.
- Let N = WIDTH/CHUNK.
- States:
  - IDLE: START=1 at an edge → latch A, B (B inverted if MODE=1), MODE; carry register = MODE; cnt=0; → RUN.
  - RUN: each edge adds chunk cnt of A, B and the carry register (via the sub-module). Writes CHUNK sum bits to RES_DATA[cnt*CHUNK +: CHUNK] and updates the carry; cnt++. On the edge with cnt==N−1 → DONE. START is ignored.
  - DONE: DONE=1 for exactly this cycle. START=1 → behaves as IDLE-accept (back-to-back, straight to RUN); otherwise → IDLE.
- Latency: START accepted at edge k → BUSY high for cycles after edges k..k+N−1 → DONE high in the cycle after edge k+N. Throughput: one op per N+1 cycles.
- Upper result bits are written on the final RUN edge, with c = final carry out:
  - add: RES_DATA[WIDTH]=c, RES_DATA[WIDTH+1]=0.
  - subtract: RES_DATA[WIDTH+1:WIDTH] = {~c, ~c}, giving the two's-complement A−B sign-extended to WIDTH+2 bits. ~c=1 means borrow / negative result.
- Result hold: RES_DATA and ZERO hold their value through IDLE until the next accepted START.
- Clearing on accept: at START accept, RES_DATA is cleared to 0 and ZERO to 0.
- Input isolation: A_DATA, B_DATA and MODE changes after acceptance have no effect on the running operation.
- CHUNK==WIDTH: N=1, so the result arrives in a single RUN cycle.

Decomposition:
- Shared package calc_pkg:
  - state enum (IDLE, RUN, DONE);
  - MODE_ADD=1'b0, MODE_SUB=1'b1.
- One combinational sub-module, calc_chunk_adder:
  - parametrised by CHUNK;
  - inputs a, b, cin; outputs sum[CHUNK], cout;
  - ripple of full-adder cells.
- Top level contains the FSM, counter, operand shift/index logic and result register.

Test Plan (WIDTH=8, CHUNK=2, N=4):
1. Add with carry: MODE=0, A=0xFF, B=0x01, START one cycle → BUSY high 4 cycles; DONE pulse 1 cycle; RES_DATA=0x100; ZERO=0.
2. Subtract, negative: MODE=1, A=0x05, B=0x07 → RES_DATA=0x3FE (−2); ZERO=0.
3. Subtract, zero: MODE=1, A=0x80, B=0x80 → RES_DATA=0x000; ZERO=1.
4. Input isolation: START with A=0x10, B=0x20 (add); on the next cycle pulse START and change to A=0xFF, B=0xFF → second START ignored; RES_DATA=0x030; exactly one DONE pulse.
5. Reset mid-operation: start A=0xAA + B=0x55; drive RST_N low for one cycle during RUN cnt=2 → BUSY, DONE, RES_DATA go 0 immediately (before the next edge); no DONE pulse; a subsequent 0x01+0x01 returns 0x002.
6. Back-to-back: hold START=1 with the first op 0x03+0x04 and the second op supplied in the DONE cycle as sub 0x00−0x01 → first DONE shows RES_DATA=0x007; second DONE exactly 5 cycles later shows RES_DATA=0x3FF.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calc datapath blocks.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Upper two result bits above the sum: carry for add, sign-extended borrow for subtract.
   function automatic logic [1:0] upper_bits(input logic mode, input logic cout);
      if (mode == MODE_SUB) begin
         return {~cout, ~cout};
      end
      return {1'b0, cout};
   endfunction

endpackage : calc_pkg

// File: rtl/calc_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module calc_chunk_adder #(
   parameter int unsigned CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[CHUNK];

endmodule : calc_chunk_adder

// File: rtl/calc_addsub_seq.sv
// Multi-cycle unsigned add/subtract: processes CHUNK bits per clock with a START/BUSY/DONE handshake.
module calc_addsub_seq
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a_data,
   input  logic [WIDTH-1:0] b_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH+1:0] res_data,
   output logic             zero
);

   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned RES_W = WIDTH + 2;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   state_e             state;
   state_e             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               mode_q;
   logic               carry_q;

   logic               accept_c;
   logic               step_c;
   logic               last_c;
   logic [CHUNK-1:0]   sum_c;
   logic               cout_c;
   logic [RES_W-1:0]   res_next_c;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      step_c     = 1'b0;
      last_c     = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            step_c = 1'b1;
            if (cnt == CNT_W'(N - 1)) begin
               last_c     = 1'b1;
               state_next = ST_DONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operands are shifted right each step, so the active chunk is always at bit 0.
   calc_chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a    (a_q[CHUNK-1:0]),
      .b    (b_q[CHUNK-1:0]),
      .cin  (carry_q),
      .sum  (sum_c),
      .cout (cout_c)
   );

   // Result with the current chunk merged in; upper bits filled on the final chunk.
   always_comb begin
      res_next_c = res_data;
      for (int unsigned i = 0; i < N; i++) begin
         if (cnt == CNT_W'(i)) begin
            res_next_c[i*CHUNK +: CHUNK] = sum_c;
         end
      end
      if (last_c) begin
         res_next_c[RES_W-1 -: 2] = upper_bits(mode_q, cout_c);
      end
   end

   // Operand, carry, counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= MODE_ADD;
         carry_q  <= 1'b0;
         cnt      <= '0;
         res_data <= '0;
         zero     <= 1'b0;
      end else if (accept_c) begin
         a_q      <= a_data;
         b_q      <= (mode == MODE_SUB) ? ~b_data : b_data;
         mode_q   <= mode;
         carry_q  <= mode;
         cnt      <= '0;
         res_data <= '0;
         zero     <= 1'b0;
      end else if (step_c) begin
         a_q      <= a_q >> CHUNK;
         b_q      <= b_q >> CHUNK;
         carry_q  <= cout_c;
         cnt      <= last_c ? '0 : cnt + CNT_W'(1);
         res_data <= res_next_c;
         if (last_c) begin
            zero <= (res_next_c == '0);
         end
      end
   end

   // Handshake outputs track the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == ST_RUN);
         done <= (state_next == ST_DONE);
      end
   end

endmodule : calc_addsub_seq

// File: tb/tb_calc_addsub_seq.sv
// Randomised and directed checks of calc_addsub_seq against an arithmetic reference model.
module tb_calc_addsub_seq;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CHUNK = 2;
   localparam int unsigned N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic [WIDTH-1:0] a_data = '0;
   logic [WIDTH-1:0] b_data = '0;
   logic             busy;
   logic             done;
   logic [WIDTH+1:0] res_data;
   logic             zero;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles of work left, pending result, visible result.
   int         m_left = 0;
   bit         m_done = 1'b0;
   logic [9:0] m_pend = '0;
   logic [9:0] m_res  = '0;
   bit         m_zero = 1'b0;

   calc_addsub_seq #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .a_data   (a_data),
      .b_data   (b_data),
      .busy     (busy),
      .done     (done),
      .res_data (res_data),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] ref_res(input logic m, input logic [7:0] a, input logic [7:0] b);
      if (m) return 10'(a) - 10'(b);
      return 10'(a) + 10'(b);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         m_pend = '0;
         m_res  = '0;
         m_zero = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left == 0 && start) begin
            m_left = N;
            m_pend = ref_res(mode, a_data, b_data);
            m_res  = '0;
            m_zero = 1'b0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_res  = m_pend;
               m_zero = (m_pend == '0);
            end
         end
      end
   end

   // Compare outputs every cycle; result and zero are meaningful whenever not busy.
   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      if (m_left == 0) begin
         chk("res_data", 32'(res_data), 32'(m_res));
         chk("zero", 32'(zero), 32'(m_zero));
      end
   end

   task automatic wait_done(input int start_cyc, output int cyc);
      cyc = start_cyc;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b, input bit iso,
                         input bit pin, input logic [9:0] exp_res, input logic exp_zero);
      int cyc;
      @(negedge clk);
      mode = m; a_data = a; b_data = b; start = 1'b1;
      @(negedge clk);
      if (iso) begin
         mode = 1'b0; a_data = 8'hFF; b_data = 8'hFF; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cyc = 2;
      end else begin
         start = 1'b0;
         mode = 1'($urandom); a_data = 8'($urandom); b_data = 8'($urandom);
         cyc = 1;
      end
      wait_done(cyc, cyc);
      if (done) begin
         chk("latency", 32'(cyc), 32'(N + 1));
         if (pin) begin
            chk("pin_res", 32'(res_data), 32'(exp_res));
            chk("pin_zero", 32'(zero), 32'(exp_zero));
         end
      end
   endtask

   initial begin
      int cyc;
      #7;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", 32'(res_data), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      #15 rst_n = 1'b1;

      run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 10'h100, 1'b0);
      run_op(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 10'h3FE, 1'b0);
      run_op(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 10'h000, 1'b1);
      run_op(1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 10'h030, 1'b0);

      // Reset in the RUN cycle where cnt==2.
      @(negedge clk);
      mode = 1'b0; a_data = 8'hAA; b_data = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_res", 32'(res_data), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      run_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b1, 10'h002, 1'b0);

      // Back-to-back: START held high, second op supplied in the DONE cycle.
      @(negedge clk);
      mode = 1'b0; a_data = 8'h03; b_data = 8'h04; start = 1'b1;
      @(negedge clk);
      wait_done(1, cyc);
      chk("b2b_first_res", 32'(res_data), 32'h007);
      chk("b2b_first_lat", 32'(cyc), 32'(N + 1));
      mode = 1'b1; a_data = 8'h00; b_data = 8'h01;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, cyc);
      chk("b2b_gap", 32'(cyc), 32'(N + 1));
      chk("b2b_second_res", 32'(res_data), 32'h3FF);
      chk("b2b_second_zero", 32'(zero), 32'd0);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 10'h0, 1'b0);
      end
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_calc_addsub_seq
